// File: rtl/mau_pkg.sv
// Shared types for the load/store unit: access sizes,
// FSM state encoding and request bundle.
package mau_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } mau_state_e;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [1:0]  off;
    logic [31:0] wdata;
  } mau_req_t;

  function automatic logic [32:0] size_bytes(
    input logic [1:0] size
  );
    logic [32:0] n;
    n = 33'd4;
    unique case (1'b1)
      size == SIZE_BYTE: n = 33'd1;
      size == SIZE_HALF: n = 33'd2;
      default:           n = 33'd4;
    endcase
    return n;
  endfunction

  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [1:0] off
  );
    logic m;
    m = 1'b0;
    unique case (1'b1)
      size == SIZE_HALF: m = off[0];
      size == SIZE_WORD: m = |off;
      default:           m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response handshake plus data-memory bus
// between the MEM stage and the load/store unit.
interface mem_access_unit_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_size,
    input  req_signed, req_addr, req_wdata,
    output req_ready,
    output resp_valid, resp_rdata, resp_err,
    output mem_addr, mem_wdata,
    output mem_read, mem_write,
    input  mem_rdata
  );

  modport master (
    output req_valid, req_we, req_size,
    output req_signed, req_addr, req_wdata,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_err,
    input  mem_addr, mem_wdata,
    input  mem_read, mem_write,
    output mem_rdata
  );

endinterface

// File: rtl/mau_lane_align.sv
// Byte-lane steering: load extract/extend and
// sub-word store merge into a little-endian word.
module mau_lane_align
  import mau_pkg::*;
(
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [31:0] rword_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] ld_data_o,
  output logic [31:0] st_word_o
);

  logic [7:0]  b;
  logic [15:0] h;
  logic [4:0]  sh;

  always_comb begin
    sh = {off_i, 3'b000};
    b  = rword_i[sh +: 8];
    h  = off_i[1] ? rword_i[31:16]
                  : rword_i[15:0];
    ld_data_o = rword_i;
    unique case (1'b1)
      size_i == SIZE_BYTE:
        ld_data_o = {{24{signed_i & b[7]}}, b};
      size_i == SIZE_HALF:
        ld_data_o = {{16{signed_i & h[15]}}, h};
      default:
        ld_data_o = rword_i;
    endcase
  end

  always_comb begin
    st_word_o = rword_i;
    unique case (1'b1)
      size_i == SIZE_BYTE:
        st_word_o[sh +: 8] = wdata_i[7:0];
      size_i == SIZE_HALF:
        if (off_i[1])
          st_word_o[31:16] = wdata_i[15:0];
        else
          st_word_o[15:0] = wdata_i[15:0];
      size_i == SIZE_WORD:
        st_word_o = wdata_i;
      default:
        st_word_o = rword_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: one request at a time, word-aligned
// memory cycles, read-modify-write for sub-word stores.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int unsigned MEM_SIZE = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_access_unit_if.slave  bus
);

  localparam logic [32:0] MEM_LIM = 33'(MEM_SIZE);

  mau_state_e  state_q, state_d;
  mau_req_t    req_q, req_d;
  logic [31:0] maddr_q, maddr_d;
  logic [31:0] mwdata_q, mwdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] ld_data;
  logic [31:0] st_word;
  logic        bad;

  mau_lane_align u_align (
    .off_i     (req_q.off),
    .size_i    (req_q.size),
    .signed_i  (req_q.sgn),
    .rword_i   (bus.mem_rdata),
    .wdata_i   (req_q.wdata),
    .ld_data_o (ld_data),
    .st_word_o (st_word)
  );

  // Range check in 33 bits so addresses near 2^32 cannot wrap.
  always_comb begin
    bad = (bus.req_size == SIZE_ILL)
       || misaligned(bus.req_size, bus.req_addr[1:0])
       || (({1'b0, bus.req_addr}
            + size_bytes(bus.req_size)) > MEM_LIM);
  end

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          req_d.we    = bus.req_we;
          req_d.size  = bus.req_size;
          req_d.sgn   = bus.req_signed;
          req_d.off   = bus.req_addr[1:0];
          req_d.wdata = bus.req_wdata;
          rdata_d     = '0;
          err_d       = bad;
          if (bad) begin
            state_d = RESP;
          end else begin
            maddr_d = {bus.req_addr[31:2], 2'b00};
            if (bus.req_we
                && bus.req_size == SIZE_WORD) begin
              mwdata_d = bus.req_wdata;
              state_d  = WR;
            end else begin
              state_d = RD;
            end
          end
        end
      end
      RD: begin
        if (req_q.we) begin
          mwdata_d = st_word;
          state_d  = WR;
        end else begin
          rdata_d = ld_data;
          state_d = RESP;
        end
      end
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      req_q    <= '0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Strobes decode straight from the state register,
  // so reset kills an in-flight write immediately.
  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign bus.mem_read   = (state_q == RD);
  assign bus.mem_write  = (state_q == WR);
  assign bus.mem_addr   = maddr_q;
  assign bus.mem_wdata  = mwdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench: load/store unit against a 256-byte
// little-endian memory model.
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  mem_access_unit_if bus ();

  mem_access_unit #(.MEM_SIZE(256)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [7:0] mem [256];
  logic [7:0] ma;

  assign ma = bus.mem_addr[7:0];
  assign bus.mem_rdata = {mem[ma + 8'd3], mem[ma + 8'd2],
                          mem[ma + 8'd1], mem[ma]};

  always @(posedge clk) begin
    if (bus.mem_write) begin
      mem[ma]        <= bus.mem_wdata[7:0];
      mem[ma + 8'd1] <= bus.mem_wdata[15:8];
      mem[ma + 8'd2] <= bus.mem_wdata[23:16];
      mem[ma + 8'd3] <= bus.mem_wdata[31:24];
    end
  end

  int rd_cnt = 0;
  int wr_cnt = 0;
  always @(negedge clk) begin
    if (bus.mem_read)  rd_cnt++;
    if (bus.mem_write) wr_cnt++;
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h",
                  tag, got, exp);
  endtask

  logic [31:0] r_data;
  logic        r_err;
  int          r_lat;
  int          r_rd;
  int          r_wr;

  task automatic xact(input logic we,
                      input logic [1:0] sz,
                      input logic sg,
                      input logic [31:0] a,
                      input logic [31:0] wd);
    int n;
    int rd0;
    int wr0;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) chk("ready_timeout", 32'd0, 32'd1);
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    r_lat = 1;
    while (!bus.resp_valid && r_lat < 10) begin
      @(negedge clk);
      r_lat++;
    end
    if (!bus.resp_valid) chk("resp_timeout", 32'd0, 32'd1);
    r_data = bus.resp_rdata;
    r_err  = bus.resp_err;
    r_rd   = rd_cnt - rd0;
    r_wr   = wr_cnt - wr0;
  endtask

  logic [1:0]  b_sz [4];
  logic        b_sg [4];
  logic [31:0] b_a  [4];
  logic [31:0] b_x  [4];

  initial begin
    int ka;
    int kr;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_size   = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_rvalid", 32'(bus.resp_valid), 32'd0);
    chk("rst_rdata", bus.resp_rdata, 32'd0);
    chk("rst_err", 32'(bus.resp_err), 32'd0);
    chk("rst_mrd", 32'(bus.mem_read), 32'd0);
    chk("rst_mwr", 32'(bus.mem_write), 32'd0);
    chk("rst_maddr", bus.mem_addr, 32'd0);
    chk("rst_mwdata", bus.mem_wdata, 32'd0);

    xact(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    chk("sw_err", 32'(r_err), 32'd0);
    chk("sw_lat", 32'(r_lat), 32'd2);
    chk("sw_rdata", r_data, 32'd0);
    chk("sw_wr", 32'(r_wr), 32'd1);
    chk("sw_rd", 32'(r_rd), 32'd0);
    xact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    chk("lw_data", r_data, 32'hDEADBEEF);
    chk("lw_err", 32'(r_err), 32'd0);
    chk("lw_lat", 32'(r_lat), 32'd2);

    xact(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
    chk("lb_s", r_data, 32'hFFFFFFDE);
    xact(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
    chk("lbu", r_data, 32'h000000DE);
    xact(1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
    chk("lh_s", r_data, 32'hFFFFDEAD);
    xact(1'b0, 2'b01, 1'b0, 32'h10, 32'h0);
    chk("lhu_lo", r_data, 32'h0000BEEF);

    xact(1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFFFF55);
    chk("sb_lat", 32'(r_lat), 32'd3);
    chk("sb_rd", 32'(r_rd), 32'd1);
    chk("sb_wr", 32'(r_wr), 32'd1);
    chk("sb_err", 32'(r_err), 32'd0);
    xact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    chk("sb_word", r_data, 32'hDEAD55EF);

    xact(1'b1, 2'b01, 1'b0, 32'h16, 32'h00001234);
    chk("sh_lat", 32'(r_lat), 32'd3);
    xact(1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
    chk("sh_word", r_data, 32'h12340000);

    xact(1'b0, 2'b10, 1'b0, 32'h12, 32'h0);
    chk("mis_w_err", 32'(r_err), 32'd1);
    chk("mis_w_data", r_data, 32'd0);
    chk("mis_w_mem", 32'(r_rd + r_wr), 32'd0);
    chk("mis_w_lat", 32'(r_lat), 32'd1);
    xact(1'b0, 2'b01, 1'b0, 32'h11, 32'h0);
    chk("mis_h_err", 32'(r_err), 32'd1);
    chk("mis_h_mem", 32'(r_rd + r_wr), 32'd0);
    xact(1'b1, 2'b11, 1'b0, 32'h10, 32'h0);
    chk("ill_err", 32'(r_err), 32'd1);
    chk("ill_mem", 32'(r_rd + r_wr), 32'd0);
    xact(1'b1, 2'b10, 1'b0, 32'hFC, 32'hCAFEF00D);
    chk("sw_fc_err", 32'(r_err), 32'd0);
    xact(1'b0, 2'b10, 1'b0, 32'hFC, 32'h0);
    chk("lw_fc", r_data, 32'hCAFEF00D);
    chk("lw_fc_err", 32'(r_err), 32'd0);
    xact(1'b0, 2'b01, 1'b1, 32'hFE, 32'h0);
    chk("lh_fe", r_data, 32'hFFFFCAFE);
    xact(1'b0, 2'b01, 1'b0, 32'hFF, 32'h0);
    chk("oor_err", 32'(r_err), 32'd1);
    chk("oor_data", r_data, 32'd0);
    chk("oor_mem", 32'(r_rd + r_wr), 32'd0);
    xact(1'b1, 2'b10, 1'b0, 32'h100, 32'h1);
    chk("oor_sw_err", 32'(r_err), 32'd1);
    chk("oor_sw_mem", 32'(r_rd + r_wr), 32'd0);

    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_size   = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'h10;
    bus.req_wdata  = 32'h000000AA;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(posedge clk);
    #2;
    chk("rstwr_pre", 32'(bus.mem_write), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstwr_mwr", 32'(bus.mem_write), 32'd0);
    chk("rstwr_mrd", 32'(bus.mem_read), 32'd0);
    chk("rstwr_ready", 32'(bus.req_ready), 32'd1);
    chk("rstwr_rvalid", 32'(bus.resp_valid), 32'd0);
    chk("rstwr_maddr", bus.mem_addr, 32'd0);
    chk("rstwr_mwdata", bus.mem_wdata, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstwr_ready2", 32'(bus.req_ready), 32'd1);
    xact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    chk("rstwr_word", r_data, 32'hDEAD55EF);

    b_sz[0] = 2'b10; b_sg[0] = 1'b0;
    b_a[0]  = 32'h10; b_x[0] = 32'hDEAD55EF;
    b_sz[1] = 2'b10; b_sg[1] = 1'b0;
    b_a[1]  = 32'hFC; b_x[1] = 32'hCAFEF00D;
    b_sz[2] = 2'b01; b_sg[2] = 1'b0;
    b_a[2]  = 32'h12; b_x[2] = 32'h0000DEAD;
    b_sz[3] = 2'b00; b_sg[3] = 1'b1;
    b_a[3]  = 32'h13; b_x[3] = 32'hFFFFFFDE;
    ka = 0;
    kr = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        if (kr < 4)
          chk($sformatf("b2b_%0d", kr),
              bus.resp_rdata, b_x[kr]);
        kr++;
      end
      if (bus.req_ready) begin
        if (ka < 4) begin
          bus.req_valid  = 1'b1;
          bus.req_we     = 1'b0;
          bus.req_size   = b_sz[ka];
          bus.req_signed = b_sg[ka];
          bus.req_addr   = b_a[ka];
          bus.req_wdata  = 32'h0;
          ka++;
        end else begin
          bus.req_valid = 1'b0;
        end
      end else begin
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_size   = 2'b10;
        bus.req_signed = 1'b1;
        bus.req_addr   = (c % 2 == 0) ? 32'h10 : 32'hFC;
        bus.req_wdata  = $urandom;
      end
    end
    bus.req_valid = 1'b0;
    chk("b2b_pulses", 32'(kr), 32'd4);
    chk("b2b_accepts", 32'(ka), 32'd4);
    xact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    chk("b2b_keep10", r_data, 32'hDEAD55EF);
    xact(1'b0, 2'b10, 1'b0, 32'hFC, 32'h0);
    chk("b2b_keepfc", r_data, 32'hCAFEF00D);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
